// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between NREQ valid/ready requesters.
// Each result is held with its requester index in a one-entry output register.
module alu_share_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [3*NREQ-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [IDW-1:0]       rsp_id,
    output logic                 rsp_zero
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t          state_reg, state_next;
    logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [31:0]     result_reg;
    logic [IDW-1:0]  id_reg;
    logic            zero_reg;

    logic [31:0]     a_arr  [NREQ];
    logic [31:0]     b_arr  [NREQ];
    logic [2:0]      op_arr [NREQ];

    logic            can_issue;
    logic            grant_found;
    logic [IDW-1:0]  grant_idx;
    logic [31:0]     a_sel, b_sel, alu_out;
    logic [2:0]      op_sel;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[32*gi +: 32];
            assign b_arr[gi]  = req_b[32*gi +: 32];
            assign op_arr[gi] = req_op[3*gi +: 3];
        end
    endgenerate

    function automatic logic [31:0] alu_calc(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
        logic [31:0] r;
        case (op)
            3'd0:    r = a | b;
            3'd1:    r = a & b;
            3'd2:    r = a ^ b;
            3'd3:    r = a + b;
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a & b);
            3'd6:    r = {31'd0, ($signed(a) < $signed(b))};
            default: r = a - b;
        endcase
        return r;
    endfunction

    assign can_issue = (state_reg == EMPTY) | rsp_ready;

    // Walk the requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (can_issue) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NREQ) idx = idx - NREQ;
                for (int i = 0; i < NREQ; i++) begin
                    if (i == idx && !grant_found && req_valid[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = IDW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n & grant_found & (grant_idx == IDW'(i));
        end
    end

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel  = a_arr[i];
                b_sel  = b_arr[i];
                op_sel = op_arr[i];
            end
        end
    end

    assign alu_out = alu_calc(a_sel, b_sel, op_sel);

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        if (grant_found) begin
            state_next  = FULL;
            rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (state_reg == FULL && rsp_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= EMPTY;
            rr_ptr_reg <= '0;
            result_reg <= '0;
            id_reg     <= '0;
            zero_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            if (grant_found) begin
                result_reg <= alu_out;
                id_reg     <= grant_idx;
                zero_reg   <= (alu_out == 32'd0);
            end
        end
    end

    assign rsp_valid  = (state_reg == FULL);
    assign rsp_result = result_reg;
    assign rsp_id     = id_reg;
    assign rsp_zero   = zero_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized bench for alu_share_arbiter against a cycle-level behavioural model
// of the output register, round-robin pointer and ALU.
module tb_alu_share_arbiter;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_a, req_b;
    logic [3*NREQ-1:0]   req_op;
    logic                rsp_valid, rsp_ready, rsp_zero;
    logic [31:0]         rsp_result;
    logic [IDW-1:0]      rsp_id;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit          m_full;
    int          m_ptr;
    logic [31:0] m_res;
    int          m_id;
    bit          m_zero;

    always #5 clk = ~clk;

    alu_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_zero(rsp_zero)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input int op);
        case (op)
            0: return a | b;
            1: return a & b;
            2: return a ^ b;
            3: return a + b;
            4: return ~(a | b);
            5: return ~(a & b);
            6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a - b;
        endcase
    endfunction

    function automatic int ref_grant();
        int i;
        if (m_full && !rsp_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input bit v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op);
        req_valid[i]       = v;
        req_a[32*i +: 32]  = a;
        req_b[32*i +: 32]  = b;
        req_op[3*i +: 3]   = op;
    endtask

    // One clock: check outputs at the falling edge, then advance the model on the rising edge.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        g = ref_grant();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        check_val("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (m_full) begin
            check_val("rsp_result", rsp_result, m_res);
            check_val("rsp_id", 32'(rsp_id), 32'(m_id));
            check_val("rsp_zero", 32'(rsp_zero), 32'(m_zero));
        end
        @(posedge clk);
        if (g >= 0) begin
            m_res  = ref_alu(req_a[32*g +: 32], req_b[32*g +: 32], int'(req_op[3*g +: 3]));
            m_id   = g;
            m_zero = (m_res == 32'd0);
            m_full = 1'b1;
            m_ptr  = (g + 1) % NREQ;
        end else if (rsp_ready) begin
            m_full = 1'b0;
        end
        #1;
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        m_ptr  = 0;
        m_res  = '0;
        m_id   = 0;
        m_zero = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        model_reset();
        #2;
        check_val("reset_ready", 32'(req_ready), 32'd0);
        check_val("reset_valid", 32'(rsp_valid), 32'd0);
        check_val("reset_result", rsp_result, 32'd0);
        check_val("reset_id", 32'(rsp_id), 32'd0);
        check_val("reset_zero", 32'(rsp_zero), 32'd0);
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD on requester 0
        set_req(0, 1, 32'd5, 32'd3, 3'd3);
        step();
        check_val("t1_result", rsp_result, 32'd8);
        check_val("t1_id", 32'(rsp_id), 32'd0);
        req_valid = '0;
        step();

        // SUB and signed SLT on requester 1
        set_req(1, 1, 32'd3, 32'd5, 3'd7);
        step();
        check_val("t2_sub", rsp_result, 32'hFFFF_FFFE);
        set_req(1, 1, 32'd3, 32'd5, 3'd6);
        step();
        check_val("t2_slt", rsp_result, 32'd1);
        set_req(1, 1, 32'hFFFF_FFFF, 32'd1, 3'd6);
        step();
        check_val("t2_slt_neg", rsp_result, 32'd1);
        check_val("t2_id", 32'(rsp_id), 32'd1);
        req_valid = '0;

        // zero flag and NAND
        set_req(0, 1, 32'd7, 32'd7, 3'd7);
        step();
        check_val("t3_zero", 32'(rsp_zero), 32'd1);
        set_req(0, 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd5);
        step();
        check_val("t3_nand", rsp_result, 32'h0FFF_0FFF);
        req_valid = '0;
        step();

        // both requesters, full throughput, then backpressure
        set_req(0, 1, 32'd10, 32'd1, 3'd3);
        set_req(1, 1, 32'd20, 32'd2, 3'd3);
        for (int k = 0; k < 6; k++) step();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) step();
        rsp_ready = 1'b1;
        step();
        step();

        // asynchronous reset while holding a result under backpressure
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(rsp_valid), 32'd0);
        check_val("async_rst_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        step();
        check_val("post_rst_id", 32'(rsp_id), 32'd0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] a, b;
                a = $urandom;
                b = ($urandom_range(0, 7) == 0) ? a : $urandom;
                set_req(i, $urandom_range(0, 3) != 0, a, b, 3'($urandom_range(0, 7)));
            end
            rsp_ready = $urandom_range(0, 9) < 7;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
